// File: rtl/packet_window_pkg.sv
// Shared types and fixed-point helpers for the packet_window streaming stage.
// Rounding is half-up on Q1.15 products; saturation limits follow the sample width.
package packet_window_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PACKET,
    DROP
  } state_t;

  // Wide enough for any product of a sample and an unsigned coefficient plus rounding.
  typedef logic signed [63:0] wide_t;

  localparam int    ROUND_SHIFT = 15;
  localparam wide_t ROUND_CONST = wide_t'(1) <<< (ROUND_SHIFT - 1);

  function automatic wide_t sat_max(input int width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  function automatic wide_t saturate(input wide_t value, input int width);
    if (value > sat_max(width)) return sat_max(width);
    if (value < sat_min(width)) return sat_min(width);
    return value;
  endfunction

endpackage

// File: rtl/window_coef_ram.sv
// Simple dual-port coefficient RAM: read-first, one-cycle read latency, powers up at INIT.
// Words are stored XOR'ed with INIT so the all-zero power-up state of the array reads as INIT.
module window_coef_ram #(
  parameter int                DEPTH  = 2048,
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT   = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; reset must leave coefficients intact.
  // NOTE: non-blocking assignments make the same-address read return the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data ^ INIT;
    rd_data <= mem[rd_addr] ^ INIT;
  end

endmodule

// File: rtl/packet_window.sv
// Windowing stage: multiplies sample n of each packet by w[n], repairs framing, 3-cycle latency.
// Define PACKET_WINDOW_STATS_EN to add saturating pkt_count / err_count outputs.
module packet_window
  import packet_window_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int COEF_WIDTH = 16,
  parameter int LENGTH     = 2048
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sink_valid,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  input  logic [WIDTH-1:0]          sink_data,
  input  logic                      coef_wr,
  input  logic [$clog2(LENGTH)-1:0] coef_addr,
  input  logic [COEF_WIDTH-1:0]     coef_data,
  output logic                      source_valid,
  output logic                      source_sop,
  output logic                      source_eop,
  output logic [WIDTH-1:0]          source_data,
  output logic                      framing_error
`ifdef PACKET_WINDOW_STATS_EN
  ,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
`endif
);

  localparam int             AW     = $clog2(LENGTH);
  localparam int             PROD_W = WIDTH + COEF_WIDTH + 1;
  localparam logic [AW-1:0]  LAST   = AW'(LENGTH - 1);

  state_t                   state, state_next;
  logic [AW-1:0]            idx, idx_next, cur_idx;
  logic                     accept, fwd_sop, fwd_eop, err_next;
  logic [COEF_WIDTH-1:0]    coef_q;

  logic                     s1_valid, s1_sop, s1_eop;
  logic signed [WIDTH-1:0]  s1_data;
  logic                     s2_valid, s2_sop, s2_eop;
  logic signed [PROD_W-1:0] s2_prod;
  wide_t                    scaled;
  logic signed [WIDTH-1:0]  sat_data;

  // A sop always restarts the index, whatever state the framer is in.
  assign cur_idx = sink_sop ? '0 : idx;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    accept     = 1'b0;
    fwd_sop    = 1'b0;
    fwd_eop    = 1'b0;
    err_next   = 1'b0;
    if (sink_valid) begin
      case (state)
        IDLE, DROP: begin
          if (sink_sop) accept = 1'b1;
          else if (state == IDLE) err_next = 1'b1;
        end
        PACKET: begin
          accept   = 1'b1;
          err_next = sink_sop;
        end
        default: ;
      endcase
      if (accept) begin
        fwd_sop = sink_sop;
        if (sink_eop) begin
          fwd_eop    = 1'b1;
          state_next = IDLE;
          idx_next   = '0;
          if (cur_idx != LAST) err_next = 1'b1;
        end else if (cur_idx == LAST) begin
          // Overlong packet: close it here and discard the tail until the next sop.
          fwd_eop    = 1'b1;
          err_next   = 1'b1;
          state_next = DROP;
          idx_next   = '0;
        end else begin
          state_next = PACKET;
          idx_next   = cur_idx + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  window_coef_ram #(
    .DEPTH  (LENGTH),
    .DATA_W (COEF_WIDTH),
    .INIT   ({1'b1, {(COEF_WIDTH-1){1'b0}}})
  ) u_coef_ram (
    .clk     (clk),
    .wr_en   (coef_wr),
    .wr_addr (coef_addr),
    .wr_data (coef_data),
    .rd_addr (cur_idx),
    .rd_data (coef_q)
  );

  assign scaled   = (wide_t'(s2_prod) + ROUND_CONST) >>> ROUND_SHIFT;
  assign sat_data = WIDTH'(saturate(scaled, WIDTH));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      source_valid  <= 1'b0;
      source_sop    <= 1'b0;
      source_eop    <= 1'b0;
      source_data   <= '0;
      framing_error <= 1'b0;
    end else begin
      s1_valid      <= accept;
      s2_valid      <= s1_valid;
      source_valid  <= s2_valid;
      source_sop    <= s2_valid & s2_sop;
      source_eop    <= s2_valid & s2_eop;
      source_data   <= sat_data;
      framing_error <= err_next;
    end
  end

  // Payload registers need no reset: they are only observed alongside their valid bits.
  always_ff @(posedge clk) begin
    s1_sop  <= fwd_sop;
    s1_eop  <= fwd_eop;
    s1_data <= $signed(sink_data);
    s2_sop  <= s1_sop;
    s2_eop  <= s1_eop;
    s2_prod <= PROD_W'(s1_data) * PROD_W'($signed({1'b0, coef_q}));
  end

`ifdef PACKET_WINDOW_STATS_EN
  logic pkt_good;
  assign pkt_good = accept && sink_eop && (cur_idx == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_good && pkt_count != '1) pkt_count <= pkt_count + 16'd1;
      if (framing_error && err_count != '1) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
